// File: rtl/pool_window_if.sv
// pool_window_if: upstream/downstream valid-ready bus of the pooling stage; master drives samples and dn_ready, slave is the pooler
interface pool_window_if #(
  parameter int NUM_WIDTH = 16,
  parameter int NUM_CH    = 4
);
  logic [NUM_CH*NUM_WIDTH-1:0] up_data;
  logic                        up_valid;
  logic                        up_ready;
  logic [NUM_CH*NUM_WIDTH-1:0] dn_data;
  logic                        dn_valid;
  logic                        dn_ready;
  modport master (output up_data, up_valid, dn_ready, input up_ready, dn_data, dn_valid);
  modport slave  (input up_data, up_valid, dn_ready, output up_ready, dn_data, dn_valid);
endinterface

// File: rtl/pool_window.sv
// pool_window: NUM_CH-channel max/avg pooling over 2^k samples; ports clk, rst, cfg_mode, cfg_win_log2, restart, bus (up_* in, dn_* out)
module pool_window #(
  parameter int NUM_WIDTH    = 16,
  parameter int NUM_CH       = 4,
  parameter int WIN_LOG2_MAX = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cfg_mode,
  input  logic [$clog2(WIN_LOG2_MAX+1)-1:0]   cfg_win_log2,
  input  logic                                restart,
  pool_window_if.slave                        bus
);
  localparam int WW = $clog2(WIN_LOG2_MAX + 1);
  localparam int AW = NUM_WIDTH + WIN_LOG2_MAX;
  localparam int CW = WIN_LOG2_MAX + 1;
  logic [CW-1:0] cnt_q, cnt_d, cnt_base, lim;
  logic mode_q, mode_d, mode_e;
  logic [WW-1:0] k_q, k_d, k_e;
  logic signed [AW-1:0] acc_q [NUM_CH];
  logic signed [AW-1:0] acc_d [NUM_CH];
  logic signed [AW-1:0] smp [NUM_CH];
  logic signed [AW-1:0] nxt [NUM_CH];
  logic [NUM_CH*NUM_WIDTH-1:0] dn_data_q, dn_data_d, res;
  logic dn_valid_q, dn_valid_d, take, first, last;
  assign bus.up_ready = ~dn_valid_q | bus.dn_ready;
  assign bus.dn_data  = dn_data_q;
  assign bus.dn_valid = dn_valid_q;
  // A restart beat behaves exactly like the first beat of a fresh window, so config
  // and limit come from the live cfg inputs whenever the window is (re)starting.
  always_comb begin
    take     = bus.up_valid & bus.up_ready;
    first    = (cnt_q == '0) || restart;
    cnt_base = restart ? '0 : cnt_q;
    mode_e   = first ? cfg_mode : mode_q;
    k_e      = first ? (cfg_win_log2 > WW'(WIN_LOG2_MAX) ? WW'(WIN_LOG2_MAX) : cfg_win_log2) : k_q;
    lim      = ~({CW{1'b1}} << k_e);
    last     = take && (cnt_base == lim);
    res      = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      smp[c]   = AW'($signed(bus.up_data[c*NUM_WIDTH +: NUM_WIDTH]));
      nxt[c]   = first ? smp[c] : mode_e ? acc_q[c] + smp[c] : (smp[c] > acc_q[c] ? smp[c] : acc_q[c]);
      res[c*NUM_WIDTH +: NUM_WIDTH] = NUM_WIDTH'(mode_e ? nxt[c] >>> k_e : nxt[c]);
      acc_d[c] = take ? nxt[c] : restart ? '0 : acc_q[c];
    end
    cnt_d      = take ? (last ? '0 : cnt_base + CW'(1)) : cnt_base;
    mode_d     = take ? mode_e : mode_q;
    k_d        = take ? k_e : k_q;
    dn_valid_d = last | (dn_valid_q & ~bus.dn_ready);
    dn_data_d  = last ? res : dn_data_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      mode_q     <= 1'b0;
      k_q        <= '0;
      dn_valid_q <= 1'b0;
      dn_data_q  <= '0;
      for (int c = 0; c < NUM_CH; c++) acc_q[c] <= '0;
    end else begin
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      k_q        <= k_d;
      dn_valid_q <= dn_valid_d;
      dn_data_q  <= dn_data_d;
      for (int c = 0; c < NUM_CH; c++) acc_q[c] <= acc_d[c];
    end
  end
endmodule

// File: tb/tb_pool_window.sv
// tb_pool_window: directed self-checking bench for pool_window with two 8-bit channels
module tb_pool_window;
  localparam int NW = 8;
  localparam int NC = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_mode = 1'b0;
  logic [2:0] cfg_win_log2 = 3'd0;
  logic restart = 1'b0;
  int tests = 0;
  int fails = 0;
  pool_window_if #(.NUM_WIDTH(NW), .NUM_CH(NC)) bus ();
  pool_window #(.NUM_WIDTH(NW), .NUM_CH(NC), .WIN_LOG2_MAX(4)) dut (
    .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_win_log2(cfg_win_log2),
    .restart(restart), .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] pk(input int a, input int b);
    return {8'(b), 8'(a)};
  endfunction
  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic beat(input int a, input int b);
    bus.up_data  = pk(a, b);
    bus.up_valid = 1'b1;
    step();
  endtask
  task automatic idle;
    bus.up_valid = 1'b0;
    bus.dn_ready = 1'b1;
    step();
  endtask
  task automatic test_reset;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    tests++; if (bus.dn_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", bus.dn_valid); end
    tests++; if (bus.dn_data !== 16'h0) begin fails++; $display("FAIL reset_data got %h want 0000", bus.dn_data); end
    tests++; if (bus.up_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", bus.up_ready); end
  endtask
  task automatic test_max;
    int a0 [4] = '{3, -5, 7, 1};
    int a1 [4] = '{-8, -2, -9, -3};
    cfg_mode = 1'b0; cfg_win_log2 = 3'd2; bus.dn_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      beat(a0[i], a1[i]);
      cfg_mode = 1'b1;
      tests++; if (bus.dn_valid !== (i == 3)) begin fails++; $display("FAIL max_valid beat%0d got %b want %b", i, bus.dn_valid, i == 3); end
    end
    tests++; if (bus.dn_data !== pk(7, -2)) begin fails++; $display("FAIL max_data got %h want %h", bus.dn_data, pk(7, -2)); end
    idle();
    tests++; if (bus.dn_valid !== 1'b0) begin fails++; $display("FAIL max_pulse got %b want 0", bus.dn_valid); end
  endtask
  task automatic test_avg;
    int a0 [4] = '{10, 11, 12, 14};
    int a1 [4] = '{-1, -2, -2, -2};
    cfg_mode = 1'b1; cfg_win_log2 = 3'd2; bus.dn_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      beat(a0[i], a1[i]);
      tests++; if (bus.dn_valid !== (i == 3)) begin fails++; $display("FAIL avg_valid beat%0d got %b want %b", i, bus.dn_valid, i == 3); end
    end
    tests++; if (bus.dn_data !== pk(11, -2)) begin fails++; $display("FAIL avg_data got %h want %h", bus.dn_data, pk(11, -2)); end
    idle();
  endtask
  task automatic test_passthru;
    logic [15:0] v;
    cfg_win_log2 = 3'd0; bus.dn_ready = 1'b1;
    for (int m = 0; m < 2; m++) begin
      cfg_mode = m[0];
      for (int i = 0; i < 6; i++) begin
        v = 16'($urandom);
        bus.up_data = v; bus.up_valid = 1'b1;
        step();
        tests++; if (bus.dn_valid !== 1'b1 || bus.dn_data !== v) begin fails++; $display("FAIL pass_m%0d_%0d got %b/%h want 1/%h", m, i, bus.dn_valid, bus.dn_data, v); end
        tests++; if (bus.up_ready !== 1'b1) begin fails++; $display("FAIL pass_ready_m%0d_%0d got %b want 1", m, i, bus.up_ready); end
      end
    end
    idle();
  endtask
  task automatic test_clamp;
    cfg_mode = 1'b1; cfg_win_log2 = 3'd7; bus.dn_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      beat(i, -1);
      tests++; if (bus.dn_valid !== (i == 15)) begin fails++; $display("FAIL clamp_valid beat%0d got %b want %b", i, bus.dn_valid, i == 15); end
    end
    tests++; if (bus.dn_data !== pk(7, -1)) begin fails++; $display("FAIL clamp_data got %h want %h", bus.dn_data, pk(7, -1)); end
    idle();
  endtask
  task automatic test_backpressure;
    cfg_mode = 1'b0; cfg_win_log2 = 3'd1; bus.dn_ready = 1'b0;
    beat(5, 1);
    tests++; if (bus.dn_valid !== 1'b0) begin fails++; $display("FAIL bp_first got %b want 0", bus.dn_valid); end
    beat(2, 6);
    tests++; if (bus.dn_valid !== 1'b1 || bus.dn_data !== pk(5, 6)) begin fails++; $display("FAIL bp_result got %b/%h want 1/%h", bus.dn_valid, bus.dn_data, pk(5, 6)); end
    bus.up_data = pk(100, 100); bus.up_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tests++; if (bus.up_ready !== 1'b0) begin fails++; $display("FAIL bp_stall_ready%0d got %b want 0", i, bus.up_ready); end
      step();
      tests++; if (bus.dn_valid !== 1'b1 || bus.dn_data !== pk(5, 6)) begin fails++; $display("FAIL bp_hold%0d got %b/%h want 1/%h", i, bus.dn_valid, bus.dn_data, pk(5, 6)); end
    end
    bus.dn_ready = 1'b1;
    #1;
    tests++; if (bus.up_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready got %b want 1", bus.up_ready); end
    step();
    tests++; if (bus.dn_valid !== 1'b0) begin fails++; $display("FAIL bp_drain got %b want 0", bus.dn_valid); end
    beat(-1, -1);
    tests++; if (bus.dn_valid !== 1'b1 || bus.dn_data !== pk(100, 100)) begin fails++; $display("FAIL bp_resume got %b/%h want 1/%h", bus.dn_valid, bus.dn_data, pk(100, 100)); end
    idle();
  endtask
  task automatic test_restart;
    cfg_mode = 1'b0; cfg_win_log2 = 3'd2; bus.dn_ready = 1'b1;
    beat(9, 9);
    beat(9, 9);
    restart = 1'b1;
    beat(1, 1);
    restart = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      beat(i, i);
      tests++; if (bus.dn_valid !== (i == 4)) begin fails++; $display("FAIL rs_valid beat%0d got %b want %b", i, bus.dn_valid, i == 4); end
    end
    tests++; if (bus.dn_data !== pk(4, 4)) begin fails++; $display("FAIL rs_data got %h want %h", bus.dn_data, pk(4, 4)); end
    beat(50, 50);
    bus.up_valid = 1'b0; restart = 1'b1;
    step();
    restart = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      beat(i, i);
      tests++; if (bus.dn_valid !== (i == 4)) begin fails++; $display("FAIL rs_idle_valid beat%0d got %b want %b", i, bus.dn_valid, i == 4); end
    end
    tests++; if (bus.dn_data !== pk(4, 4)) begin fails++; $display("FAIL rs_idle_data got %h want %h", bus.dn_data, pk(4, 4)); end
    idle();
  endtask
  task automatic test_reset_pending;
    cfg_mode = 1'b0; cfg_win_log2 = 3'd2; bus.dn_ready = 1'b1;
    beat(50, 50);
    beat(60, 60);
    rst = 1'b1; bus.up_valid = 1'b0;
    step();
    rst = 1'b0;
    tests++; if (bus.dn_valid !== 1'b0 || bus.dn_data !== 16'h0) begin fails++; $display("FAIL rp_partial got %b/%h want 0/0000", bus.dn_valid, bus.dn_data); end
    cfg_win_log2 = 3'd0; bus.dn_ready = 1'b0;
    beat(33, 33);
    tests++; if (bus.dn_valid !== 1'b1) begin fails++; $display("FAIL rp_pending got %b want 1", bus.dn_valid); end
    rst = 1'b1; bus.up_data = pk(77, 77); bus.dn_ready = 1'b1;
    step();
    rst = 1'b0; bus.up_valid = 1'b0;
    tests++; if (bus.dn_valid !== 1'b0 || bus.dn_data !== 16'h0) begin fails++; $display("FAIL rp_drop got %b/%h want 0/0000", bus.dn_valid, bus.dn_data); end
    tests++; if (bus.up_ready !== 1'b1) begin fails++; $display("FAIL rp_ready got %b want 1", bus.up_ready); end
    cfg_mode = 1'b1; cfg_win_log2 = 3'd1;
    beat(2, -3);
    tests++; if (bus.dn_valid !== 1'b0) begin fails++; $display("FAIL rp_first got %b want 0", bus.dn_valid); end
    beat(5, -4);
    tests++; if (bus.dn_valid !== 1'b1 || bus.dn_data !== pk(3, -4)) begin fails++; $display("FAIL rp_clean got %b/%h want 1/%h", bus.dn_valid, bus.dn_data, pk(3, -4)); end
    idle();
  endtask
  initial begin
    bus.up_data = '0; bus.up_valid = 1'b0; bus.dn_ready = 1'b1;
    test_reset();
    test_max();
    test_avg();
    test_passthru();
    test_clamp();
    test_backpressure();
    test_restart();
    test_reset_pending();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pool_window.md
Name: pool_window

Overview:
- Multi-channel windowed pooling stage placed after the convolution/activation datapath.
- Reduces NUM_CH parallel signed streams over a configurable window of 2^k samples.
- Two modes: max or average. Emits one pooled vector per window on a valid/ready output.
- Adds what the single-channel max-only pooler lacks: window counting, averaging, channel parallelism, output valid and backpressure.

Parameters:
- NUM_WIDTH, 16, signed two's-complement width of each channel sample.
- NUM_CH, 4, number of parallel channels packed in the data buses.
- WIN_LOG2_MAX, 4, largest supported window exponent (window ≤ 2^WIN_LOG2_MAX samples).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- cfg_mode  input  1  0 = max pooling, 1 = average pooling.
- cfg_win_log2  input  clog2(WIN_LOG2_MAX+1)  window exponent k; window = 2^k samples.
- restart  input  1  abort the current window; discard partial result.
- up_data  input  NUM_CH*NUM_WIDTH  channel c occupies bits [c*NUM_WIDTH +: NUM_WIDTH].
- up_valid  input  1  up_data valid.
- up_ready  output  1  block accepts a beat; beat accepted when up_valid & up_ready.
- dn_data  output  NUM_CH*NUM_WIDTH  pooled vector, same packing.
- dn_valid  output  1  dn_data valid.
- dn_ready  input  1  consumer accepts; transfer when dn_valid & dn_ready.

Behaviour:
- Reset (rst=1 at a clock edge): dn_valid=0, dn_data=0, sample counter=0, accumulators=0, window config cleared.
  - rst overrides every other input, including mid-window and with a pending output; the pending output is dropped.
- up_ready = ~dn_valid | dn_ready (combinational); up_ready=1 after reset.
- Config latch: cfg_mode and cfg_win_log2 are captured on the first accepted beat of each window (counter==0). Changes mid-window take no effect until the next window.
- Window exponent clamp: cfg_win_log2 > WIN_LOG2_MAX is treated as WIN_LOG2_MAX.
- Per-channel accumulator width: NUM_WIDTH+WIN_LOG2_MAX, signed.
  - First beat of a window: accumulator loads the sample (sign-extended).
  - Later beats, max mode: accumulator = sample if sample > accumulator (signed compare); ties keep the held value.
  - Later beats, avg mode: accumulator += sign-extended sample. No overflow is possible by construction.
- Counter:
  - Increments on each accepted beat.
  - On the accepted beat where counter == 2^k − 1, the window completes and the counter returns to 0.
- Result:
  - Max mode: final max.
  - Avg mode: (sum including the completing beat) >>> k, arithmetic shift, rounding toward −inf, truncated to NUM_WIDTH. The truncation is lossless.
- Latency:
  - dn_valid rises on the clock edge that accepts the completing beat; dn_data is valid in the following cycle.
  - k=0 gives a 1-cycle registered pass-through in both modes.
- Output hold: dn_data and dn_valid are held stable while dn_valid & ~dn_ready.
  - Accept of dn_ready with no new completion: dn_valid→0 next edge.
  - dn_ready and a completing beat in the same cycle: the new result is loaded and dn_valid stays 1 (back-to-back windows at full rate).
- restart:
  - restart=1 without an accepted beat: counter→0; partial accumulation discarded.
  - restart=1 with an accepted beat: the partial is discarded and that beat becomes the first sample of a new window, with config latched in that cycle.
  - restart never affects dn_valid/dn_data already pending.
- Stall: when up_ready=0, beats are not accepted and the counter and accumulators hold.
- Channels are fully independent; only the counter and config are shared.

Test Plan:
- Max mode, NUM_CH=2, NUM_WIDTH=8, k=2. ch0 stream 3,−5,7,1; ch1 stream −8,−2,−9,−3. Required: one dn_valid pulse after the 4th beat, carrying ch0=7, ch1=−2.
- Avg mode, k=2. ch0 stream 10,11,12,14 (sum 47); ch1 stream −1,−2,−2,−2 (sum −7). Required: ch0=11, ch1=−2 (floor of −1.75).
- k=0 pass-through in both modes with a random stream and dn_ready=1. Required: dn_data equals each input one cycle later; up_ready stays 1.
- Backpressure, k=1. Hold dn_ready=0 after the first result; present 3 more valid beats. Required: up_ready=0 throughout; dn_data is held; no beats consumed. On dn_ready=1 the held result transfers, and accepting then resumes.
- restart mid-window, k=2, max mode. Accept 9,9 (no restart), then restart with beat 1, then 2,3,4. Required: result 4; the 9s are discarded.
- Reset with a pending output and a partial window. Required: next cycle dn_valid=0, dn_data=0. The next 2^k beats form a clean window with config latched after reset.
